// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths and types for the out-of-order core slice.
//   RSV_ID_W   - reservation-station / ROB tag width carried on the CDB
//   DATA_W     - operand / result width
//   CDB_W      - common data bus payload {tag, data}
//   REG_ADDR_W - architectural register address width
//   rob_entry_t - one reorder-buffer slot
package fcpu_pkg;
   localparam int RSV_ID_W   = 5;
   localparam int DATA_W     = 32;
   localparam int CDB_W      = RSV_ID_W + DATA_W;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     data;
   } rob_entry_t;
endpackage

// File: rtl/rob_read_port.sv
// rob_read_port: one operand lookup port of the reorder buffer.
//   rd_id            - tag requested by dispatch
//   ent_valid/done/data - ROB entry selected by rd_id's index bits
//   cdb_valid/tag/data  - current CDB broadcast, used as a same-cycle bypass
//   rd_ready/rd_data    - operand available and its value (0 when not ready)
module rob_read_port
   import fcpu_pkg::*;
#(
   parameter int ROB_ID_W = 4
) (
   input  logic [RSV_ID_W-1:0] rd_id,
   input  logic                ent_valid,
   input  logic                ent_done,
   input  logic [DATA_W-1:0]   ent_data,
   input  logic                cdb_valid,
   input  logic [RSV_ID_W-1:0] cdb_tag,
   input  logic [DATA_W-1:0]   cdb_data,
   output logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data
);
   // Tags with bits set above the index never name a ROB entry.
   logic in_range;
   assign in_range = ((rd_id >> ROB_ID_W) == '0);

   always_comb begin
      rd_ready = 1'b0;
      rd_data  = '0;
      if (in_range && ent_valid && !ent_done && cdb_valid && (cdb_tag == rd_id)) begin
         rd_ready = 1'b1;
         rd_data  = cdb_data;
      end else if (in_range && ent_valid && ent_done) begin
         rd_ready = 1'b1;
         rd_data  = ent_data;
      end
   end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order buffer. Allocates destination tags at
// dispatch, captures results from the CDB, serves operand lookups and retires
// results in program order to the register file.
//   clk, nrst          - clock, asynchronous active-low reset
//   i_valid/i_dest     - dispatch allocation request and its dest register
//   i_ready            - an entry can be allocated this cycle
//   o_alloc_id         - tag the next allocation receives
//   rd_id/rd_ready/rd_data - two operand lookup ports
//   cdb_valid/cdb      - result broadcast {tag, data}
//   c_valid/c_id/c_reg/c_data, c_ready - in-order retirement handshake
//   i_flush            - discard every entry
//   o_count            - number of occupied entries
module reorder_buffer
   import fcpu_pkg::*;
#(
   parameter int ROB_ID_W   = 4,
   parameter int REG_ADDR_W = fcpu_pkg::REG_ADDR_W
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          i_valid,
   input  logic [REG_ADDR_W-1:0]         i_dest,
   output logic                          i_ready,
   output logic [RSV_ID_W-1:0]           o_alloc_id,
   input  logic [1:0][RSV_ID_W-1:0]      rd_id,
   output logic [1:0]                    rd_ready,
   output logic [1:0][DATA_W-1:0]        rd_data,
   input  logic                          cdb_valid,
   input  logic [CDB_W-1:0]              cdb,
   output logic                          c_valid,
   output logic [RSV_ID_W-1:0]           c_id,
   output logic [REG_ADDR_W-1:0]         c_reg,
   output logic [DATA_W-1:0]             c_data,
   input  logic                          c_ready,
   input  logic                          i_flush,
   output logic [ROB_ID_W:0]             o_count
);
   localparam int ROB_N = 1 << ROB_ID_W;

   rob_entry_t            rob_q [ROB_N];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ROB_ID_W:0]     head_q, tail_q;
   logic [ROB_ID_W-1:0]   head_idx, tail_idx, cdb_idx;
   logic [RSV_ID_W-1:0]   cdb_tag;
   logic [DATA_W-1:0]     cdb_data;
   logic                  full, alloc, capture, retire;

   assign head_idx = head_q[ROB_ID_W-1:0];
   assign tail_idx = tail_q[ROB_ID_W-1:0];
   assign full     = (head_idx == tail_idx) && (head_q[ROB_ID_W] != tail_q[ROB_ID_W]);
   assign o_count  = tail_q - head_q;

   assign i_ready    = !full && !i_flush;
   assign o_alloc_id = RSV_ID_W'(tail_idx);
   assign alloc      = i_valid && i_ready;

   assign cdb_tag  = cdb[CDB_W-1 -: RSV_ID_W];
   assign cdb_data = cdb[DATA_W-1:0];
   assign cdb_idx  = cdb_tag[ROB_ID_W-1:0];
   // Entry must already be valid before the edge, so a broadcast to the slot
   // being allocated this cycle is dropped.
   assign capture  = cdb_valid && !i_flush && ((cdb_tag >> ROB_ID_W) == '0) &&
                     rob_q[cdb_idx].valid && !rob_q[cdb_idx].done;

   assign c_valid = rob_q[head_idx].valid && rob_q[head_idx].done && !i_flush;
   assign c_id    = RSV_ID_W'(head_idx);
   assign c_reg   = rob_q[head_idx].dest;
   assign c_data  = rob_q[head_idx].data;
   assign retire  = c_valid && c_ready;

   // Allocate, capture and retire always hit distinct entries: the allocated
   // slot is invalid, the captured one is valid and not done, the retired one
   // is done.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < ROB_N; i++) rob_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < ROB_N; i++) rob_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (alloc) begin
            rob_q[tail_idx] <= '{valid: 1'b1, done: 1'b0, dest: i_dest, data: '0};
            tail_q          <= tail_q + (ROB_ID_W+1)'(1);
         end
         if (capture) begin
            rob_q[cdb_idx].done <= 1'b1;
            rob_q[cdb_idx].data <= cdb_data;
         end
         if (retire) begin
            rob_q[head_idx] <= '0;
            head_q          <= head_q + (ROB_ID_W+1)'(1);
         end
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_rd
      rob_read_port #(.ROB_ID_W(ROB_ID_W)) u_port (
         .rd_id     (rd_id[k]),
         .ent_valid (rob_q[rd_id[k][ROB_ID_W-1:0]].valid),
         .ent_done  (rob_q[rd_id[k][ROB_ID_W-1:0]].done),
         .ent_data  (rob_q[rd_id[k][ROB_ID_W-1:0]].data),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .rd_ready  (rd_ready[k]),
         .rd_data   (rd_data[k])
      );
   end
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
   import fcpu_pkg::*;

   logic                      clk = 1'b0;
   logic                      nrst;
   logic                      i_valid;
   logic [REG_ADDR_W-1:0]     i_dest;
   logic                      i_ready;
   logic [RSV_ID_W-1:0]       o_alloc_id;
   logic [1:0][RSV_ID_W-1:0]  rd_id;
   logic [1:0]                rd_ready;
   logic [1:0][DATA_W-1:0]    rd_data;
   logic                      cdb_valid;
   logic [CDB_W-1:0]          cdb;
   logic                      c_valid;
   logic [RSV_ID_W-1:0]       c_id;
   logic [REG_ADDR_W-1:0]     c_reg;
   logic [DATA_W-1:0]         c_data;
   logic                      c_ready;
   logic                      i_flush;
   logic [4:0]                o_count;

   int n_chk  = 0;
   int n_fail = 0;

   reorder_buffer #(.ROB_ID_W(4), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_dest(i_dest), .i_ready(i_ready),
      .o_alloc_id(o_alloc_id), .rd_id(rd_id), .rd_ready(rd_ready), .rd_data(rd_data),
      .cdb_valid(cdb_valid), .cdb(cdb), .c_valid(c_valid), .c_id(c_id), .c_reg(c_reg),
      .c_data(c_data), .c_ready(c_ready), .i_flush(i_flush), .o_count(o_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_valid = 1'b0; i_dest = '0; cdb_valid = 1'b0; cdb = '0;
      c_ready = 1'b0; i_flush = 1'b0; rd_id = '0;
   endtask

   task automatic set_cdb(input logic [RSV_ID_W-1:0] tag, input logic [DATA_W-1:0] data);
      cdb_valid = 1'b1;
      cdb       = {tag, data};
   endtask

   task automatic do_flush();
      idle();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      nrst = 1'b0;
      #12;
      n_chk++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
      n_chk++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
      n_chk++; if (o_alloc_id !== 5'd0) begin n_fail++; $display("FAIL reset_alloc_id: got %0d want 0", o_alloc_id); end
      n_chk++; if (rd_ready !== 2'b00) begin n_fail++; $display("FAIL reset_rd_ready: got %b want 00", rd_ready); end
      tick();
      nrst = 1'b1;
      #2;
      n_chk++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
      tick();
   endtask

   task automatic test_order();
      idle();
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'b1; i_dest = REG_ADDR_W'(k + 1);
         #2;
         n_chk++; if (o_alloc_id !== 5'(k)) begin n_fail++; $display("FAIL order_alloc_id%0d: got %0d want %0d", k, o_alloc_id, k); end
         tick();
      end
      i_valid = 1'b0;
      #2;
      n_chk++; if (o_count !== 5'd3) begin n_fail++; $display("FAIL order_count: got %0d want 3", o_count); end
      n_chk++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL order_cvalid_idle: got %b want 0", c_valid); end
      c_ready = 1'b1;
      set_cdb(5'd2, 32'hBEEF);
      tick();
      set_cdb(5'd0, 32'h11);
      #2;
      n_chk++; if (c_valid !== 1'b0) begin n_fail++; $display("FAIL order_cvalid_early: got %b want 0", c_valid); end
      tick();
      cdb_valid = 1'b0; c_ready = 1'b0;
      #2;
      n_chk++; if ({c_valid, c_id, c_reg, c_data} !== {1'b1, 5'd0, 5'd1, 32'h11})
         begin n_fail++; $display("FAIL order_ret0: got v=%b id=%0d r=%0d d=%h want 1/0/1/11", c_valid, c_id, c_reg, c_data); end
      tick();
      #2;
      n_chk++; if ({c_valid, c_id, c_data} !== {1'b1, 5'd0, 32'h11})
         begin n_fail++; $display("FAIL order_hold: got v=%b id=%0d d=%h want 1/0/11", c_valid, c_id, c_data); end
      c_ready = 1'b1;
      set_cdb(5'd1, 32'h22);
      tick();
      cdb_valid = 1'b0;
      #2;
      n_chk++; if ({c_valid, c_id, c_reg, c_data} !== {1'b1, 5'd1, 5'd2, 32'h22})
         begin n_fail++; $display("FAIL order_ret1: got v=%b id=%0d r=%0d d=%h want 1/1/2/22", c_valid, c_id, c_reg, c_data); end
      tick();
      #2;
      n_chk++; if ({c_valid, c_id, c_reg, c_data} !== {1'b1, 5'd2, 5'd3, 32'hBEEF})
         begin n_fail++; $display("FAIL order_ret2: got v=%b id=%0d r=%0d d=%h want 1/2/3/beef", c_valid, c_id, c_reg, c_data); end
      tick();
      c_ready = 1'b0;
      #2;
      n_chk++; if ({c_valid, o_count} !== {1'b0, 5'd0})
         begin n_fail++; $display("FAIL order_drained: got v=%b cnt=%0d want 0/0", c_valid, o_count); end
   endtask

   task automatic test_full_wrap();
      do_flush();
      for (int k = 0; k < 16; k++) begin
         i_valid = 1'b1; i_dest = REG_ADDR_W'(k);
         #2;
         n_chk++; if (o_alloc_id !== 5'(k)) begin n_fail++; $display("FAIL full_alloc_id%0d: got %0d want %0d", k, o_alloc_id, k); end
         tick();
      end
      // Still requesting: a full buffer must refuse.
      set_cdb(5'd0, 32'h55);
      #2;
      n_chk++; if ({i_ready, o_count} !== {1'b0, 5'd16})
         begin n_fail++; $display("FAIL full_state: got rdy=%b cnt=%0d want 0/16", i_ready, o_count); end
      tick();
      cdb_valid = 1'b0;
      c_ready   = 1'b1;
      #2;
      n_chk++; if ({c_valid, i_ready, o_count} !== {1'b1, 1'b0, 5'd16})
         begin n_fail++; $display("FAIL full_retire_cycle: got v=%b rdy=%b cnt=%0d want 1/0/16", c_valid, i_ready, o_count); end
      tick();
      c_ready = 1'b0;
      #2;
      n_chk++; if ({i_ready, o_count, o_alloc_id} !== {1'b1, 5'd15, 5'd0})
         begin n_fail++; $display("FAIL full_after_retire: got rdy=%b cnt=%0d id=%0d want 1/15/0", i_ready, o_count, o_alloc_id); end
      tick();
      i_valid = 1'b0;
      #2;
      n_chk++; if ({i_ready, o_count, o_alloc_id} !== {1'b0, 5'd16, 5'd1})
         begin n_fail++; $display("FAIL full_wrapped: got rdy=%b cnt=%0d id=%0d want 0/16/1", i_ready, o_count, o_alloc_id); end
   endtask

   task automatic test_bypass();
      do_flush();
      for (int k = 0; k < 6; k++) begin
         i_valid = 1'b1; i_dest = REG_ADDR_W'(k + 8);
         tick();
      end
      i_valid = 1'b0;
      rd_id[0] = 5'd5; rd_id[1] = 5'd5;
      #2;
      n_chk++; if (rd_ready[0] !== 1'b0) begin n_fail++; $display("FAIL byp_inflight: got %b want 0", rd_ready[0]); end
      set_cdb(5'd5, 32'hCAFE);
      #2;
      n_chk++; if ({rd_ready, rd_data[0], rd_data[1]} !== {2'b11, 32'hCAFE, 32'hCAFE})
         begin n_fail++; $display("FAIL byp_same_cycle: got rdy=%b d0=%h d1=%h want 11/cafe/cafe", rd_ready, rd_data[0], rd_data[1]); end
      tick();
      // Second broadcast to a done entry must not overwrite or bypass.
      set_cdb(5'd5, 32'h1234);
      #2;
      n_chk++; if ({rd_ready[0], rd_data[0]} !== {1'b1, 32'hCAFE})
         begin n_fail++; $display("FAIL byp_done_stored: got rdy=%b d=%h want 1/cafe", rd_ready[0], rd_data[0]); end
      tick();
      // Out-of-range tag (bit 4 set) aliases index 3 but must be ignored.
      set_cdb(5'h13, 32'h99);
      rd_id[1] = 5'd3;
      tick();
      cdb_valid = 1'b0;
      #2;
      n_chk++; if ({rd_ready, rd_data[0]} !== {2'b01, 32'hCAFE})
         begin n_fail++; $display("FAIL byp_range_and_keep: got rdy=%b d0=%h want 01/cafe", rd_ready, rd_data[0]); end
      c_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_cdb(5'(k), 32'(k + 100));
         tick();
      end
      cdb_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      c_ready = 1'b0;
      #2;
      n_chk++; if ({o_count, rd_ready[0], rd_data[0]} !== {5'd0, 1'b0, 32'h0})
         begin n_fail++; $display("FAIL byp_retired: got cnt=%0d rdy=%b d=%h want 0/0/0", o_count, rd_ready[0], rd_data[0]); end
      rd_id = '0;
   endtask

   task automatic test_flush();
      do_flush();
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1; i_dest = REG_ADDR_W'(k);
         tick();
      end
      i_valid = 1'b0;
      set_cdb(5'd0, 32'hA0);
      tick();
      set_cdb(5'd1, 32'hA1);
      tick();
      cdb_valid = 1'b0;
      #2;
      n_chk++; if ({c_valid, o_count} !== {1'b1, 5'd5})
         begin n_fail++; $display("FAIL flush_pre: got v=%b cnt=%0d want 1/5", c_valid, o_count); end
      i_flush = 1'b1; c_ready = 1'b1; i_valid = 1'b1;
      #2;
      n_chk++; if ({c_valid, i_ready} !== 2'b00)
         begin n_fail++; $display("FAIL flush_during: got v=%b rdy=%b want 0/0", c_valid, i_ready); end
      tick();
      idle();
      #2;
      n_chk++; if ({o_count, c_valid, o_alloc_id} !== {5'd0, 1'b0, 5'd0})
         begin n_fail++; $display("FAIL flush_after: got cnt=%0d v=%b id=%0d want 0/0/0", o_count, c_valid, o_alloc_id); end
      // Broadcast to the slot being allocated in the same cycle is dropped.
      i_valid = 1'b1; i_dest = 5'd7;
      set_cdb(5'd0, 32'hDEAD);
      tick();
      idle();
      #2;
      n_chk++; if ({o_count, rd_ready[0], c_valid} !== {5'd1, 1'b0, 1'b0})
         begin n_fail++; $display("FAIL flush_alloc_cdb: got cnt=%0d rdy=%b v=%b want 1/0/0", o_count, rd_ready[0], c_valid); end
   endtask

   task automatic test_async_reset();
      idle();
      set_cdb(5'd0, 32'h77);
      tick();
      cdb_valid = 1'b0;
      #2;
      n_chk++; if ({c_valid, c_data} !== {1'b1, 32'h77})
         begin n_fail++; $display("FAIL arst_pre: got v=%b d=%h want 1/77", c_valid, c_data); end
      nrst = 1'b0;
      #1;
      n_chk++; if ({c_valid, o_count} !== {1'b0, 5'd0})
         begin n_fail++; $display("FAIL arst_immediate: got v=%b cnt=%0d want 0/0", c_valid, o_count); end
      tick();
      nrst = 1'b1;
      i_valid = 1'b1; i_dest = 5'd9;
      #2;
      n_chk++; if (o_alloc_id !== 5'd0) begin n_fail++; $display("FAIL arst_alloc_id: got %0d want 0", o_alloc_id); end
      tick();
      i_valid = 1'b0;
      #2;
      n_chk++; if (o_count !== 5'd1) begin n_fail++; $display("FAIL arst_count: got %0d want 1", o_count); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full_wrap();
      test_bypass();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order buffer that sits upstream of reservation_station.
- At dispatch it allocates the destination tag (RSV_ID) that each reservation-station entry carries.
- It snoops the CDB to capture results, supplies operand values for in-flight tags to the dispatcher, and retires results in program order to the register file.
- A flush clears all speculative entries.

Parameters:
- ROB_ID_W, 4, log2 of entry count (16 entries); must be <= RSV_ID_W.
- REG_ADDR_W, 5, architectural destination register address width.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset; asynchronous, active-low.
- i_valid  in  1  dispatch requests an entry.
- i_dest  in  REG_ADDR_W  destination register of the dispatched instruction.
- i_ready  out  1  entry available.
- o_alloc_id  out  RSV_ID_W  tag the next allocation receives (tail index, zero-extended).
- rd_id  in  2 x RSV_ID_W  operand tags looked up by dispatch.
- rd_ready  out  2  operand value available.
- rd_data  out  2 x DATA_W  operand value.
- cdb_valid  in  1  CDB broadcast valid.
- cdb  in  CDB_W  {tag[RSV_ID_W], data[DATA_W]}.
- c_valid  out  1  head entry ready to retire.
- c_id  out  RSV_ID_W  head tag.
- c_reg  out  REG_ADDR_W  head destination register.
- c_data  out  DATA_W  head result.
- c_ready  in  1  register file accepts the retirement.
- i_flush  in  1  discard all entries.
- o_count  out  ROB_ID_W+1  occupied entries.

Behaviour:
- Storage per entry: valid, done, dest, data. Pointers head and tail are ROB_ID_W+1 bits, with the MSB used as the wrap bit.
- Empty when head == tail. Full when the index bits are equal and the wrap bits differ. o_count = tail - head, modulo 2^(ROB_ID_W+1).
- Reset (async, nrst=0): all valid/done cleared, head = tail = 0. Outputs during and after reset: c_valid=0, rd_ready=0, o_alloc_id=0, o_count=0, i_ready=1 once nrst is high.
- i_ready = !full && !i_flush. It does not depend on c_ready, so a full buffer refuses allocation even when a retirement happens in the same cycle.
- Allocate on i_valid && i_ready:
  - entry[tail] <= {valid=1, done=0, dest=i_dest, data=0}; tail++.
  - Tag = o_alloc_id in that cycle. Visible in state next cycle.
- CDB capture on cdb_valid:
  - Tag bits above ROB_ID_W must be 0; otherwise the broadcast is ignored.
  - If entry[idx].valid && !done: done <= 1, data <= cdb data.
  - A broadcast to an invalid or already-done entry is ignored.
  - Result is visible on c_* / rd_* next cycle.
- Retire:
  - c_valid = entry[head].valid && entry[head].done && !i_flush. c_id/c_reg/c_data come from entry[head].
  - All c_* outputs are combinational from registered state, so the earliest retirement is the cycle after CDB capture.
  - On c_valid && c_ready: entry[head] cleared, head++.
  - While c_ready=0, all c_* outputs hold stable.
- Simultaneous events in one cycle: allocate, CDB capture and retire act on distinct entries and all take effect.
  - Retire needs done=1.
  - A CDB to the entry being allocated is ignored, because that entry was invalid before the edge.
- Read ports (combinational), for each k:
  - If cdb_valid and cdb tag == rd_id[k] and the entry is valid and not done: rd_ready=1, rd_data = cdb data (bypass).
  - Else if the entry is valid and done: rd_ready=1, rd_data = stored data.
  - Else: rd_ready=0, rd_data=0.
  - The dispatcher treats rd_ready=0 as "wait on the CDB" when the tag is in flight, or "use the register file" when the tag has already retired. Tracking which case applies is the dispatcher's responsibility.
- Flush: i_flush=1 overrides allocate, CDB capture and retire in that cycle. Next cycle all valid=0, head = tail = 0.
- Latency: allocate to CDB-capable is 1 cycle; CDB to c_valid is 1 cycle; throughput is 1 allocation + 1 retirement per cycle.

Decomposition:
- fcpu_pkg gains:
  - rob_entry_t packed struct {valid, done, dest, data}.
  - REG_ADDR_W constant.
  - Existing RSV_ID_W, DATA_W and CDB_W are reused.
- One natural sub-module: rob_read_port, which implements the per-port bypass/select logic and is instantiated twice.
- Pointer and storage logic stay in reorder_buffer.

Test Plan:
- Reset, then three allocations with dest 1,2,3 -> o_alloc_id 0,1,2; o_count=3; c_valid=0.
- CDB tag 2 data 0xBEEF, then tag 0 0x11, then tag 1 0x22 -> c_valid rises only after tag 0 is captured; retire order is (0,r1,0x11), (1,r2,0x22), (2,r3,0xBEEF).
- Sixteen allocations -> i_ready=0 and o_count=16. Complete and retire tag 0 -> i_ready=1 next cycle; the next allocation gets id 0 (wrap) and the wrap bit toggles.
- rd_id[0]=5 (in flight) with CDB tag 5 data 0xCAFE in the same cycle -> rd_ready[0]=1, rd_data[0]=0xCAFE. The same tag after retirement -> rd_ready[0]=0.
- Five entries in flight, two done, i_flush=1 while c_ready=1 -> no retirement in that cycle; next cycle o_count=0, c_valid=0, o_alloc_id=0.
- nrst dropped mid-stream with c_valid=1 -> c_valid=0 immediately without waiting for a clock edge. After release, an allocation gets id 0.
